// File: rtl/ddr_arb_pkg.sv
// Shared types and constants for the 2:1 DDR read-port arbiter.
// Holds the arbiter state enum, the AXI field widths, the AR payload
// struct and the default outstanding-beat budget.
package ddr_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned ID_W   = 8;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned RESP_W = 2;

    // ARID/RID bit that carries the requester index
    localparam int unsigned ID_OWNER_BIT = 7;

    localparam int unsigned DEF_MAX_OUTSTANDING = 64;
    localparam int unsigned DEF_CNT_W           = 13;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   id;
        logic [LEN_W-1:0]  len;
    } ar_req_t;

endpackage

// File: rtl/rd_beat_tracker.sv
// Outstanding read-beat counter for one requester.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   inc, inc_len  add inc_len+1 beats (an AR issue of that length)
//   dec           retire one beat
//   chk_len       arlen of the pending request for the budget check
//   eligible_c    cnt + chk_len + 1 <= MAX_OUTSTANDING
//   busy_c        cnt != 0
//   zero_c        cnt == 0
module rd_beat_tracker
    import ddr_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic [LEN_W-1:0] inc_len,
    input  logic             dec,
    input  logic [LEN_W-1:0] chk_len,
    output logic             eligible_c,
    output logic             busy_c,
    output logic             zero_c
);

    localparam int unsigned SUM_W = CNT_W + 1;

    logic [CNT_W-1:0] cnt;
    logic [SUM_W-1:0] cnt_ext;
    logic [SUM_W-1:0] chk_sum;
    logic [SUM_W-1:0] inc_amt;
    logic [SUM_W-1:0] cnt_nxt;

    assign cnt_ext = {1'b0, cnt};

    // Budget check in one extra bit so the sum cannot wrap before the compare
    assign chk_sum    = cnt_ext + SUM_W'(chk_len) + SUM_W'(1);
    assign eligible_c = (chk_sum <= SUM_W'(MAX_OUTSTANDING));
    assign zero_c     = (cnt == '0);
    assign busy_c     = ~zero_c;

    // Issue and retire may coincide; net change is then +inc_len
    always_comb begin
        inc_amt = '0;
        if (inc) begin
            inc_amt = SUM_W'(inc_len) + SUM_W'(1);
        end
        cnt_nxt = cnt_ext + inc_amt - SUM_W'(dec);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/ddr_rd_arbiter_2to1.sv
// Shares one 64-bit AXI read port between two requesters.
// AR: round-robin between eligible requesters, requester index placed in
//     ARID[7], fields latched and held on m_ar* for one ISSUE phase.
// R:  steered combinationally by RID[7]; beats for a requester with no
//     outstanding beats are drained and flag err_orphan (sticky).
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   s0_ar*/s1_ar*                requester AR channels
//   s0_r*/s1_r*                  requester R channels
//   s0_busy/s1_busy              requester has outstanding beats
//   m_ar*, m_r*                  controller-side AR and R channels
//   err_orphan                   sticky unowned-beat flag
module ddr_rd_arbiter_2to1
    import ddr_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] s0_araddr,
    input  logic [ID_W-1:0]   s0_arid,
    input  logic [LEN_W-1:0]  s0_arlen,
    input  logic              s0_arvalid,
    output logic              s0_arready,
    output logic [DATA_W-1:0] s0_rdata,
    output logic [ID_W-1:0]   s0_rid,
    output logic              s0_rlast,
    output logic [RESP_W-1:0] s0_rresp,
    output logic              s0_rvalid,
    input  logic              s0_rready,
    output logic              s0_busy,

    input  logic [ADDR_W-1:0] s1_araddr,
    input  logic [ID_W-1:0]   s1_arid,
    input  logic [LEN_W-1:0]  s1_arlen,
    input  logic              s1_arvalid,
    output logic              s1_arready,
    output logic [DATA_W-1:0] s1_rdata,
    output logic [ID_W-1:0]   s1_rid,
    output logic              s1_rlast,
    output logic [RESP_W-1:0] s1_rresp,
    output logic              s1_rvalid,
    input  logic              s1_rready,
    output logic              s1_busy,

    output logic [ADDR_W-1:0] m_araddr,
    output logic [ID_W-1:0]   m_arid,
    output logic [LEN_W-1:0]  m_arlen,
    output logic              m_arvalid,
    input  logic              m_arready,

    input  logic [DATA_W-1:0] m_rdata,
    input  logic [ID_W-1:0]   m_rid,
    input  logic              m_rlast,
    input  logic [RESP_W-1:0] m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready,

    output logic              err_orphan
);

    arb_state_t state, state_nxt;
    logic       prio,  prio_nxt;
    logic       gnt,   gnt_nxt;
    ar_req_t    ar_q,  ar_nxt;
    logic       win;

    ar_req_t    s_req [2];
    logic [1:0] s_arvalid;
    logic [1:0] budget_ok_c;
    logic [1:0] elig_c;
    logic [1:0] busy_c;
    logic [1:0] zero_c;
    logic [1:0] inc_c;
    logic [1:0] dec_c;

    logic       ar_hs_c;
    logic       owner;
    logic       orphan_c;
    logic       beat_hs_c;

    assign s_req[0]  = '{addr: s0_araddr, id: s0_arid, len: s0_arlen};
    assign s_req[1]  = '{addr: s1_araddr, id: s1_arid, len: s1_arlen};
    assign s_arvalid = {s1_arvalid, s0_arvalid};
    assign elig_c    = s_arvalid & budget_ok_c;

    // Per-requester outstanding-beat budget
    for (genvar g = 0; g < 2; g++) begin : g_trk
        assign inc_c[g] = ar_hs_c   & (gnt   == 1'(g));
        assign dec_c[g] = beat_hs_c & (owner == 1'(g));

        rd_beat_tracker #(
            .MAX_OUTSTANDING (MAX_OUTSTANDING),
            .CNT_W           (CNT_W)
        ) u_trk (
            .clk        (clk),
            .rst        (rst),
            .inc        (inc_c[g]),
            .inc_len    (ar_q.len),
            .dec        (dec_c[g]),
            .chk_len    (s_req[g].len),
            .eligible_c (budget_ok_c[g]),
            .busy_c     (busy_c[g]),
            .zero_c     (zero_c[g])
        );
    end

    // AR arbitration: next state and latched request
    always_comb begin
        state_nxt = state;
        prio_nxt  = prio;
        gnt_nxt   = gnt;
        ar_nxt    = ar_q;
        win       = 1'b0;
        case (state)
            IDLE: begin
                if (elig_c != 2'b00) begin
                    win       = (elig_c == 2'b11) ? prio : elig_c[1];
                    gnt_nxt   = win;
                    ar_nxt    = s_req[win];
                    ar_nxt.id[ID_OWNER_BIT] = win;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (m_arready) begin
                    prio_nxt  = ~gnt;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prio       <= 1'b0;
            gnt        <= 1'b0;
            ar_q       <= '0;
            m_arvalid  <= 1'b0;
            err_orphan <= 1'b0;
        end else begin
            state      <= state_nxt;
            prio       <= prio_nxt;
            gnt        <= gnt_nxt;
            ar_q       <= ar_nxt;
            m_arvalid  <= (state_nxt == ISSUE);
            if (orphan_c) begin
                err_orphan <= 1'b1;
            end
        end
    end

    assign m_araddr = ar_q.addr;
    assign m_arid   = ar_q.id;
    assign m_arlen  = ar_q.len;

    assign ar_hs_c    = (state == ISSUE) & m_arready;
    assign s0_arready = ar_hs_c & ~gnt;
    assign s1_arready = ar_hs_c &  gnt;

    // R steering; an unowned beat is accepted here and never forwarded
    assign owner     = m_rid[ID_OWNER_BIT];
    assign orphan_c  = m_rvalid & zero_c[owner];
    assign m_rready  = orphan_c | (owner ? s1_rready : s0_rready);
    assign beat_hs_c = m_rvalid & m_rready & ~orphan_c;

    assign s0_rvalid = m_rvalid & ~orphan_c & ~owner;
    assign s1_rvalid = m_rvalid & ~orphan_c &  owner;

    assign s0_rid   = {1'b0, m_rid[ID_OWNER_BIT-1:0]};
    assign s1_rid   = {1'b0, m_rid[ID_OWNER_BIT-1:0]};
    assign s0_rdata = m_rdata;
    assign s1_rdata = m_rdata;
    assign s0_rlast = m_rlast;
    assign s1_rlast = m_rlast;
    assign s0_rresp = m_rresp;
    assign s1_rresp = m_rresp;

    assign s0_busy = busy_c[0];
    assign s1_busy = busy_c[1];

endmodule

// File: tb/tb_ddr_rd_arbiter_2to1.sv
// Self-checking bench for ddr_rd_arbiter_2to1: directed scenarios followed
// by randomized traffic compared against a transaction-level model.
module tb_ddr_rd_arbiter_2to1;

    localparam int unsigned MAXO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s0_araddr, s1_araddr, m_araddr;
    logic [7:0]  s0_arid, s1_arid, m_arid;
    logic [7:0]  s0_arlen, s1_arlen, m_arlen;
    logic        s0_arvalid, s1_arvalid, s0_arready, s1_arready;
    logic [63:0] s0_rdata, s1_rdata, m_rdata;
    logic [7:0]  s0_rid, s1_rid, m_rid;
    logic        s0_rlast, s1_rlast, m_rlast;
    logic [1:0]  s0_rresp, s1_rresp, m_rresp;
    logic        s0_rvalid, s1_rvalid, m_rvalid;
    logic        s0_rready, s1_rready, m_rready;
    logic        s0_busy, s1_busy;
    logic        m_arvalid, m_arready;
    logic        err_orphan;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ddr_rd_arbiter_2to1 #(.MAX_OUTSTANDING(MAXO), .CNT_W(13)) dut (
        .clk(clk), .rst(rst),
        .s0_araddr(s0_araddr), .s0_arid(s0_arid), .s0_arlen(s0_arlen),
        .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
        .s0_rdata(s0_rdata), .s0_rid(s0_rid), .s0_rlast(s0_rlast),
        .s0_rresp(s0_rresp), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s0_busy(s0_busy),
        .s1_araddr(s1_araddr), .s1_arid(s1_arid), .s1_arlen(s1_arlen),
        .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
        .s1_rdata(s1_rdata), .s1_rid(s1_rid), .s1_rlast(s1_rlast),
        .s1_rresp(s1_rresp), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
        .s1_busy(s1_busy),
        .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rid(m_rid), .m_rlast(m_rlast),
        .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .err_orphan(err_orphan)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        s0_araddr = '0; s0_arid = '0; s0_arlen = '0; s0_arvalid = 1'b0; s0_rready = 1'b0;
        s1_araddr = '0; s1_arid = '0; s1_arlen = '0; s1_arvalid = 1'b0; s1_rready = 1'b0;
        m_arready = 1'b0; m_rdata = '0; m_rid = '0; m_rlast = 1'b0; m_rresp = '0;
        m_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    // Random-phase stimulus holders and reference model
    bit          rq_v   [2];
    logic [31:0] rq_a   [2];
    logic [7:0]  rq_id  [2];
    logic [7:0]  rq_len [2];
    int          mo     [2];
    bit          iss;
    int          g;
    int          pr;
    logic [31:0] la;
    logic [7:0]  lid;
    logic [7:0]  llen;
    bit          merr;
    int          r;
    int          win;
    bit          e0, e1;
    logic        own;
    bit          orph;
    logic        exp_rr;
    logic [63:0] dat;

    initial begin
        rst = 1'b1;
        idle_inputs();

        // Reset state
        do_reset();
        settle();
        chk("rst_arvalid", m_arvalid, 0);
        chk("rst_arid", m_arid, 0);
        chk("rst_araddr", m_araddr, 0);
        chk("rst_arlen", m_arlen, 0);
        chk("rst_busy0", s0_busy, 0);
        chk("rst_busy1", s1_busy, 0);
        chk("rst_err", err_orphan, 0);

        // Single request from s0 and its four beats
        s0_arvalid = 1'b1; s0_araddr = 32'h100; s0_arid = 8'h05; s0_arlen = 8'd3;
        m_arready = 1'b1;
        settle();
        chk("t1_arvalid_n", m_arvalid, 0);
        step();
        settle();
        chk("t1_arvalid", m_arvalid, 1);
        chk("t1_arid", m_arid, 8'h05);
        chk("t1_araddr", m_araddr, 32'h100);
        chk("t1_arlen", m_arlen, 3);
        chk("t1_arready0", s0_arready, 1);
        chk("t1_arready1", s1_arready, 0);
        step();
        s0_arvalid = 1'b0;
        settle();
        chk("t1_idle", m_arvalid, 0);
        for (int k = 0; k < 4; k++) begin
            dat = {$urandom, $urandom};
            m_rvalid = 1'b1; m_rid = 8'h05; m_rlast = (k == 3); m_rdata = dat;
            s0_rready = 1'b1;
            settle();
            chk("t1_busy", s0_busy, 1);
            chk("t1_rvalid0", s0_rvalid, 1);
            chk("t1_rvalid1", s1_rvalid, 0);
            chk("t1_rready", m_rready, 1);
            chk("t1_rdata", s0_rdata, dat);
            chk("t1_rlast", s0_rlast, (k == 3));
            step();
        end
        m_rvalid = 1'b0; m_rlast = 1'b0;
        settle();
        chk("t1_busy_done", s0_busy, 0);
        chk("t1_err", err_orphan, 0);

        // Contention: grants alternate starting with s0
        do_reset();
        s0_arvalid = 1'b1; s0_arid = 8'h11; s0_arlen = 8'd0; s0_araddr = 32'hA000;
        s1_arvalid = 1'b1; s1_arid = 8'h22; s1_arlen = 8'd0; s1_araddr = 32'hB000;
        m_arready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            settle();
            chk("t2_arvalid", m_arvalid, 1);
            chk("t2_arid", m_arid, (k % 2 == 0) ? 8'h11 : 8'hA2);
            chk("t2_araddr", m_araddr, (k % 2 == 0) ? 32'hA000 : 32'hB000);
            step();
        end
        s0_arvalid = 1'b0; s1_arvalid = 1'b0;

        // Throttle: s1 fills its budget, further s1 requests wait for a beat
        do_reset();
        s1_arvalid = 1'b1; s1_arid = 8'h01; s1_arlen = 8'd15; m_arready = 1'b1;
        step();
        settle();
        chk("t3_arid_big", m_arid, 8'h81);
        chk("t3_arlen_big", m_arlen, 15);
        step();
        s1_arid = 8'h02; s1_arlen = 8'd0;
        step();
        settle();
        chk("t3_blocked_a", m_arvalid, 0);
        chk("t3_busy1", s1_busy, 1);
        step();
        settle();
        chk("t3_blocked_b", m_arvalid, 0);
        s0_arvalid = 1'b1; s0_arid = 8'h07; s0_arlen = 8'd0;
        step();
        settle();
        chk("t3_s0_grant", m_arvalid, 1);
        chk("t3_s0_arid", m_arid, 8'h07);
        step();
        s0_arvalid = 1'b0;
        m_rvalid = 1'b1; m_rid = 8'h81; s1_rready = 1'b1;
        settle();
        chk("t3_beat_rvalid", s1_rvalid, 1);
        chk("t3_still_blocked", m_arvalid, 0);
        step();
        m_rvalid = 1'b0;
        settle();
        chk("t3_idle_cycle", m_arvalid, 0);
        step();
        settle();
        chk("t3_s1_grant", m_arvalid, 1);
        chk("t3_s1_arid", m_arid, 8'h82);
        step();
        s1_arvalid = 1'b0;

        // R steering and backpressure
        do_reset();
        s1_arvalid = 1'b1; s1_arid = 8'h03; s1_arlen = 8'd0; m_arready = 1'b1;
        step();
        step();
        s1_arvalid = 1'b0;
        m_rvalid = 1'b1; m_rid = 8'h83; s1_rready = 1'b0; s0_rready = 1'b1;
        settle();
        chk("t4_rvalid1", s1_rvalid, 1);
        chk("t4_rvalid0", s0_rvalid, 0);
        chk("t4_rready_bp", m_rready, 0);
        chk("t4_rid1", s1_rid, 8'h03);
        step();
        settle();
        chk("t4_busy_held", s1_busy, 1);
        chk("t4_rvalid_held", s1_rvalid, 1);
        s1_rready = 1'b1;
        settle();
        chk("t4_rready", m_rready, 1);
        step();
        m_rvalid = 1'b0;
        settle();
        chk("t4_busy_done", s1_busy, 0);
        chk("t4_err", err_orphan, 0);

        // Orphan beat to s1 with nothing outstanding
        m_rvalid = 1'b1; m_rid = 8'h80; s1_rready = 1'b0;
        settle();
        chk("t5_rready", m_rready, 1);
        chk("t5_rvalid1", s1_rvalid, 0);
        chk("t5_rvalid0", s0_rvalid, 0);
        chk("t5_err_pre", err_orphan, 0);
        step();
        m_rvalid = 1'b0;
        settle();
        chk("t5_err_set", err_orphan, 1);
        step();
        settle();
        chk("t5_err_held", err_orphan, 1);

        // Reset in the middle of traffic
        do_reset();
        settle();
        chk("t6_err_clr", err_orphan, 0);
        s0_arvalid = 1'b1; s0_arid = 8'h09; s0_arlen = 8'd3; m_arready = 1'b1;
        step();
        step();
        s0_arvalid = 1'b0;
        s1_arvalid = 1'b1; s1_arid = 8'h04; s1_arlen = 8'd0; m_arready = 1'b0;
        step();
        settle();
        chk("t6_issue", m_arvalid, 1);
        chk("t6_busy_pre", s0_busy, 1);
        rst = 1'b1;
        step();
        settle();
        chk("t6_arvalid_rst", m_arvalid, 0);
        chk("t6_busy_rst", s0_busy, 0);
        rst = 1'b0;
        s1_arvalid = 1'b0;
        m_rvalid = 1'b1; m_rid = 8'h09; s0_rready = 1'b1;
        settle();
        chk("t6_stale_rready", m_rready, 1);
        chk("t6_stale_rvalid", s0_rvalid, 0);
        step();
        m_rvalid = 1'b0;
        settle();
        chk("t6_stale_err", err_orphan, 1);

        // Randomized traffic against the transaction model
        do_reset();
        for (int i = 0; i < 2; i++) begin
            rq_v[i] = 1'b0; mo[i] = 0;
            rq_a[i] = '0; rq_id[i] = '0; rq_len[i] = '0;
        end
        iss = 1'b0; g = 0; pr = 0; merr = 1'b0;
        la = '0; lid = '0; llen = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!rq_v[i] && $urandom_range(0, 2) == 0) begin
                    rq_v[i]   = 1'b1;
                    rq_a[i]   = $urandom;
                    rq_id[i]  = 8'($urandom);
                    rq_len[i] = 8'($urandom_range(0, 6));
                end
            end
            s0_arvalid = rq_v[0]; s0_araddr = rq_a[0]; s0_arid = rq_id[0]; s0_arlen = rq_len[0];
            s1_arvalid = rq_v[1]; s1_araddr = rq_a[1]; s1_arid = rq_id[1]; s1_arlen = rq_len[1];
            m_arready = ($urandom_range(0, 3) != 0);
            r = int'($urandom_range(0, 1));
            if (mo[r] == 0) r = 1 - r;
            if (mo[r] > 0 && $urandom_range(0, 1) == 1) begin
                m_rvalid = 1'b1;
                m_rid    = {1'(r), 7'($urandom)};
            end else begin
                m_rvalid = 1'b0;
                m_rid    = 8'($urandom);
            end
            m_rdata   = {$urandom, $urandom};
            m_rlast   = 1'($urandom);
            m_rresp   = 2'($urandom);
            s0_rready = 1'($urandom);
            s1_rready = 1'($urandom);
            settle();

            own    = m_rid[7];
            orph   = m_rvalid && (mo[own] == 0);
            exp_rr = orph ? 1'b1 : (own ? s1_rready : s0_rready);

            chk("rnd_arvalid", m_arvalid, iss);
            if (iss) begin
                chk("rnd_arid", m_arid, lid);
                chk("rnd_araddr", m_araddr, la);
                chk("rnd_arlen", m_arlen, llen);
            end
            chk("rnd_arready0", s0_arready, iss && g == 0 && m_arready);
            chk("rnd_arready1", s1_arready, iss && g == 1 && m_arready);
            chk("rnd_rready", m_rready, exp_rr);
            chk("rnd_rvalid0", s0_rvalid, m_rvalid && !orph && own == 1'b0);
            chk("rnd_rvalid1", s1_rvalid, m_rvalid && !orph && own == 1'b1);
            chk("rnd_rid1", s1_rid, {1'b0, m_rid[6:0]});
            chk("rnd_rdata0", s0_rdata, m_rdata);
            chk("rnd_busy0", s0_busy, mo[0] != 0);
            chk("rnd_busy1", s1_busy, mo[1] != 0);
            chk("rnd_err", err_orphan, merr);

            // Advance the model across the coming clock edge
            if (iss) begin
                if (m_arready) begin
                    mo[g]   = mo[g] + int'(llen) + 1;
                    pr      = 1 - g;
                    iss     = 1'b0;
                    rq_v[g] = 1'b0;
                end
            end else begin
                e0 = rq_v[0] && (mo[0] + int'(rq_len[0]) + 1 <= int'(MAXO));
                e1 = rq_v[1] && (mo[1] + int'(rq_len[1]) + 1 <= int'(MAXO));
                if (e0 || e1) begin
                    win  = (e0 && e1) ? pr : (e1 ? 1 : 0);
                    iss  = 1'b1;
                    g    = win;
                    la   = rq_a[win];
                    llen = rq_len[win];
                    lid  = {1'(win), rq_id[win][6:0]};
                end
            end
            if (m_rvalid && exp_rr && !orph) mo[own] = mo[own] - 1;
            if (orph) merr = 1'b1;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
